// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling
// and a saturating count of hazard bubbles inserted into the EX stage.
module id_ex_pipe_reg #(
  parameter int                 DATA_W    = 32,
  parameter int                 CTRL_W    = 13,
  parameter int                 REG_W     = 5,
  parameter logic [CTRL_W-1:0]  CTRL_NOP  = CTRL_W'(1),
  parameter int                 MEMRD_BIT = 0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pc_4_in,
  input  logic [DATA_W-1:0] rs_in,
  input  logic [DATA_W-1:0] rt_in,
  input  logic [DATA_W-1:0] offset_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [REG_W-1:0]  if_id_rs,
  input  logic [REG_W-1:0]  if_id_rt,
  input  logic [REG_W-1:0]  if_id_rd,
  output logic [DATA_W-1:0] pc_4_out,
  output logic [DATA_W-1:0] rs_out,
  output logic [DATA_W-1:0] rt_out,
  output logic [DATA_W-1:0] offset_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [REG_W-1:0]  id_ex_rs,
  output logic [REG_W-1:0]  id_ex_rt,
  output logic [REG_W-1:0]  id_ex_rd,
  output logic              out_valid,
  output logic              load_use_hazard,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } action_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] pc_4_q,    pc_4_d;
  logic [DATA_W-1:0] rs_q,      rs_d;
  logic [DATA_W-1:0] rt_q,      rt_d;
  logic [DATA_W-1:0] offset_q,  offset_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [REG_W-1:0]  rs_num_q,  rs_num_d;
  logic [REG_W-1:0]  rt_num_q,  rt_num_d;
  logic [REG_W-1:0]  rd_num_q,  rd_num_d;
  logic              valid_q,   valid_d;
  logic [CNT_W-1:0]  bcnt_q,    bcnt_d;
  logic              hazard;
  action_e           action;

  // A load in EX whose destination is a source of the real instruction in ID.
  assign hazard = valid_q && ctrl_q[MEMRD_BIT] && (rt_num_q != '0) && in_valid &&
                  ((rt_num_q == if_id_rs) || (rt_num_q == if_id_rt));

  always_comb begin
    action = ACT_LOAD;
    if (flush)       action = ACT_FLUSH;
    else if (stall)  action = ACT_HOLD;
    else if (hazard) action = ACT_BUBBLE;
  end

  always_comb begin
    pc_4_d   = pc_4_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    offset_d = offset_q;
    ctrl_d   = ctrl_q;
    rs_num_d = rs_num_q;
    rt_num_d = rt_num_q;
    rd_num_d = rd_num_q;
    valid_d  = valid_q;
    bcnt_d   = bcnt_q;
    case (action)
      ACT_FLUSH, ACT_BUBBLE: begin
        pc_4_d   = '0;
        rs_d     = '0;
        rt_d     = '0;
        offset_d = '0;
        ctrl_d   = CTRL_NOP;
        rs_num_d = '0;
        rt_num_d = '0;
        rd_num_d = '0;
        valid_d  = 1'b0;
        if (action == ACT_BUBBLE) bcnt_d = sat_inc(bcnt_q);
      end
      ACT_LOAD: begin
        pc_4_d   = pc_4_in;
        rs_d     = rs_in;
        rt_d     = rt_in;
        offset_d = offset_in;
        ctrl_d   = in_valid ? control_in : CTRL_NOP;
        rs_num_d = if_id_rs;
        rt_num_d = if_id_rt;
        rd_num_d = if_id_rd;
        valid_d  = in_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_4_q   <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      offset_q <= '0;
      ctrl_q   <= CTRL_NOP;
      rs_num_q <= '0;
      rt_num_q <= '0;
      rd_num_q <= '0;
      valid_q  <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      pc_4_q   <= pc_4_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      offset_q <= offset_d;
      ctrl_q   <= ctrl_d;
      rs_num_q <= rs_num_d;
      rt_num_q <= rt_num_d;
      rd_num_q <= rd_num_d;
      valid_q  <= valid_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign pc_4_out        = pc_4_q;
  assign rs_out          = rs_q;
  assign rt_out          = rt_q;
  assign offset_out      = offset_q;
  assign control_out     = ctrl_q;
  assign id_ex_rs        = rs_num_q;
  assign id_ex_rt        = rt_num_q;
  assign id_ex_rd        = rd_num_q;
  assign out_valid       = valid_q;
  assign load_use_hazard = hazard;
  assign bubble_count    = bcnt_q;

endmodule
